// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for a small combinational instruction memory.
// Captures one instruction per cycle into an output slot handed to decode over valid/ready.
module fetch_sequencer #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned PROG_LEN = 13,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] PC_out,
    input  logic [31:0]       IR_in,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W-1:0] END_PC  = ADDR_W'(PROG_LEN);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               handshake;
    logic               adv;

    assign handshake = valid_q && instr_ready;
    assign adv       = !valid_q || instr_ready;

    // Next-state and datapath; branch outranks the normal fetch/drain action.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        count_d    = count_q;

        if (handshake && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    count_d = '0;
                end
            end
            S_RUN, S_DRAIN: begin
                if (branch_taken) begin
                    valid_d = 1'b0;
                    pc_d    = branch_target;
                    state_d = (branch_target < END_PC) ? S_RUN : S_DONE;
                end else if (state_q == S_RUN) begin
                    if (adv) begin
                        instr_d    = IR_in;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + ADDR_W'(1);
                        if (pc_q == LAST_PC) begin
                            state_d = S_DRAIN;
                        end
                    end
                end else if (!valid_q || instr_ready) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign PC_out      = pc_q;
    assign instr_out   = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fetch_count = count_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table-driven full run plus hand sequences
// for stall, branch, out-of-range branch, mid-run reset and restart.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  PC_out;
    logic [31:0] IR_in;
    logic [31:0] instr_out;
    logic [3:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [3:0]  branch_target;
    logic        busy;
    logic        done;
    logic [7:0]  fetch_count;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.ADDR_W(4), .PROG_LEN(13), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .PC_out        (PC_out),
        .IR_in         (IR_in),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .busy          (busy),
        .done          (done),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [3:0] a);
        return {a, 12'h5A5, 12'h000, a};
    endfunction

    // Combinational instruction memory.
    assign IR_in = mem_word(PC_out);

    typedef struct {
        logic       start;
        logic       ready;
        logic [3:0] exp_pc;
        logic [3:0] exp_ipc;
        logic       exp_valid;
        logic       exp_busy;
        logic       exp_done;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] pc, input logic [3:0] ipc,
                             input logic valid, input logic bsy, input logic dn,
                             input logic [7:0] cnt);
        check({tag, ".pc"}, 32'(PC_out), 32'(pc));
        check({tag, ".ipc"}, 32'(instr_pc), 32'(ipc));
        check({tag, ".valid"}, 32'(instr_valid), 32'(valid));
        check({tag, ".busy"}, 32'(busy), 32'(bsy));
        check({tag, ".done"}, 32'(done), 32'(dn));
        check({tag, ".cnt"}, 32'(fetch_count), 32'(cnt));
        if (valid) check({tag, ".instr"}, instr_out, mem_word(ipc));
    endtask

    // Drive one cycle of inputs, clock, then sample 1 time unit after the edge.
    task automatic step(input logic st, input logic rdy, input logic br, input logic [3:0] tgt);
        start         = st;
        instr_ready   = rdy;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
        start        = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        // Full run with ready held high: start, 13 captures, then the drain handshake.
        vecs[0] = '{start: 1'b1, ready: 1'b1, exp_pc: 4'd0, exp_ipc: 4'd0, exp_valid: 1'b0,
                    exp_busy: 1'b1, exp_done: 1'b0, exp_cnt: 8'd0};
        for (int k = 1; k <= 13; k++) begin
            vecs[k] = '{start: 1'b0, ready: 1'b1, exp_pc: 4'(k), exp_ipc: 4'(k - 1),
                        exp_valid: 1'b1, exp_busy: 1'b1, exp_done: 1'b0, exp_cnt: 8'(k - 1)};
        end
        vecs[14] = '{start: 1'b0, ready: 1'b1, exp_pc: 4'd13, exp_ipc: 4'd12, exp_valid: 1'b0,
                     exp_busy: 1'b0, exp_done: 1'b1, exp_cnt: 8'd13};

        reset = 1'b1; start = 1'b0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_target = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check_all("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check("reset.instr", instr_out, 32'h0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].start, vecs[i].ready, 1'b0, 4'd0);
            check_all($sformatf("run[%0d]", i), vecs[i].exp_pc, vecs[i].exp_ipc,
                      vecs[i].exp_valid, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_cnt);
        end

        // Restart from DONE, then stall three cycles with instr_pc=2.
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check_all("restart", 4'd0, 4'd12, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("pre_stall", 4'd3, 4'd2, 1'b1, 1'b1, 1'b0, 8'd2);
        for (int i = 0; i < 3; i++) begin
            step(i == 1, 1'b0, 1'b0, 4'd0);
            check_all($sformatf("stall[%0d]", i), 4'd3, 4'd2, 1'b1, 1'b1, 1'b0, 8'd2);
        end
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("resume", 4'd4, 4'd3, 1'b1, 1'b1, 1'b0, 8'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("at_pc7", 4'd8, 4'd7, 1'b1, 1'b1, 1'b0, 8'd7);

        // Branch to 11 while instr_pc=7; the handshake in the branch cycle still counts.
        step(1'b0, 1'b1, 1'b1, 4'd11);
        check_all("br11", 4'd11, 4'd7, 1'b0, 1'b1, 1'b0, 8'd8);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("br11+1", 4'd12, 4'd11, 1'b1, 1'b1, 1'b0, 8'd8);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("br11+2", 4'd13, 4'd12, 1'b1, 1'b1, 1'b0, 8'd9);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("br11_done", 4'd13, 4'd12, 1'b0, 1'b0, 1'b1, 8'd10);

        // Out-of-range branch goes straight to DONE; later branches are ignored.
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check_all("br14_pre", 4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 4'd14);
        check_all("br14", 4'd14, 4'd0, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b1, 1'b1, 4'd3);
        check_all("br_in_done", 4'd14, 4'd0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Reset mid-run at PC_out=5, then refetch from 0.
        step(1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("pre_reset", 4'd5, 4'd4, 1'b1, 1'b1, 1'b0, 8'd4);
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0, 4'd0);
        reset = 1'b0;
        check_all("mid_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check("mid_reset.instr", instr_out, 32'h0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("idle_hold", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("refetch", 4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
